// File: rtl/pad_exerciser_pkg.sv
// rtl/pad_exerciser_pkg.sv - shared types and constants for the pad exerciser
package pad_exerciser_pkg;

    typedef enum logic [1:0] {
        MODE_INVERT = 2'd0,
        MODE_PASS   = 2'd1,
        MODE_WALK   = 2'd2,
        MODE_LFSR   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Right-shifting Galois step; taps fold in when the bit shifted out is 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/pad_exerciser_if.sv
// rtl/pad_exerciser_if.sv - pad, control and flag signals of the pad exerciser
interface pad_exerciser_if #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 4,
    parameter int NFLAG = 2,
    parameter int DIV_W = 16
);
    logic [IN_W-1:0]  in;
    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [NFLAG-1:0] flag_clr;
    logic [OUT_W-1:0] out;
    logic [NFLAG-1:0] flag;
    logic             step;

    modport master (
        output in, en, mode, div, flag_clr,
        input  out, flag, step
    );

    modport slave (
        input  in, en, mode, div, flag_clr,
        output out, flag, step
    );
endinterface

// File: rtl/pad_exerciser_flag_capture.sv
// rtl/pad_exerciser_flag_capture.sv - synchronised rising-edge sticky flag for one pad
module flag_capture (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_in,
    input  logic clr,
    output logic flag
);
    logic sync1_q, sync2_q, sync3_q, flag_q;
    logic sync1_d, sync2_d, sync3_d, flag_d;

    // A new edge wins over a simultaneous clear so no event is lost.
    always_comb begin
        sync1_d = pad_in;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        flag_d  = (sync2_q & ~sync3_q) | (flag_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            flag_q  <= flag_d;
        end
    end

    assign flag = flag_q;
endmodule

// File: rtl/pad_exerciser.sv
// rtl/pad_exerciser.sv - output pad pattern engine plus per-pad sticky edge flags
module pad_exerciser
    import pad_exerciser_pkg::*;
#(
    parameter int IN_W  = 11,
    parameter int OUT_W = 4,
    parameter int NFLAG = 2,
    parameter int DIV_W = 16
) (
    input logic             wb_clk,
    input logic             wb_rst_n,
    pad_exerciser_if.slave  bus
);
    localparam logic [OUT_W-1:0] WALK_INIT = OUT_W'(1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] walk_q, walk_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             step_q, step_d;
    logic [NFLAG-1:0] flag_w;
    logic             unused_in;

    logic [OUT_W-1:0] walk_rot;
    logic [15:0]      lfsr_nx;

    assign walk_rot  = {walk_q[OUT_W-2:0], walk_q[OUT_W-1]};
    assign lfsr_nx   = lfsr_next(lfsr_q);
    assign unused_in = ^bus.in;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        walk_d  = walk_q;
        lfsr_d  = lfsr_q;
        out_d   = out_q;
        step_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                out_d = '0;
                if (bus.en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                cnt_d   = '0;
                walk_d  = WALK_INIT;
                lfsr_d  = LFSR_SEED;
                mode_d  = mode_e'(bus.mode);
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.en) begin
                    out_d   = '0;
                    state_d = ST_IDLE;
                end else if (mode_e'(bus.mode) != mode_q) begin
                    state_d = ST_LOAD;
                end else begin
                    case (mode_q)
                        MODE_INVERT: out_d = ~bus.in[OUT_W-1:0];
                        MODE_PASS:   out_d = bus.in[OUT_W-1:0];
                        default: begin
                            // >= so that lowering div mid-run steps immediately.
                            if (cnt_q >= bus.div) begin
                                step_d = 1'b1;
                                cnt_d  = '0;
                                if (mode_q == MODE_WALK) begin
                                    walk_d = walk_rot;
                                    out_d  = walk_rot;
                                end else begin
                                    lfsr_d = lfsr_nx;
                                    out_d  = lfsr_nx[OUT_W-1:0];
                                end
                            end else begin
                                cnt_d = cnt_q + DIV_W'(1);
                                out_d = (mode_q == MODE_WALK) ? walk_q : lfsr_q[OUT_W-1:0];
                            end
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_INVERT;
            cnt_q   <= '0;
            walk_q  <= WALK_INIT;
            lfsr_q  <= LFSR_SEED;
            out_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            walk_q  <= walk_d;
            lfsr_q  <= lfsr_d;
            out_q   <= out_d;
            step_q  <= step_d;
        end
    end

    for (genvar g = 0; g < NFLAG; g++) begin : g_flag
        flag_capture u_flag_capture (
            .clk    (wb_clk),
            .rst_n  (wb_rst_n),
            .pad_in (bus.in[g]),
            .clr    (bus.flag_clr[g]),
            .flag   (flag_w[g])
        );
    end

    assign bus.out  = out_q;
    assign bus.step = step_q;
    assign bus.flag = flag_w;
endmodule

// File: tb/tb_pad_exerciser.sv
// tb/tb_pad_exerciser.sv - directed self-checking bench for pad_exerciser
module tb_pad_exerciser;
    logic wb_clk = 1'b0;
    logic wb_rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 wb_clk = ~wb_clk;

    pad_exerciser_if #(.IN_W(11), .OUT_W(4), .NFLAG(2), .DIV_W(16)) bus ();

    pad_exerciser #(.IN_W(11), .OUT_W(4), .NFLAG(2), .DIV_W(16)) dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .bus      (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge wb_clk);
        #1;
    endtask

    logic [3:0] walk_out [17] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4,
                                  4'h8, 4'h8, 4'h8, 4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    logic       walk_stp [17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] lfsr_out [4]  = '{4'h0, 4'h8, 4'hC, 4'hE};

    initial begin
        wb_rst_n     = 1'b0;
        bus.in       = '0;
        bus.en       = 1'b0;
        bus.mode     = 2'd0;
        bus.div      = '0;
        bus.flag_clr = '0;
        tick(3);
        wb_rst_n = 1'b1;
        tick(1);
        check("reset_out", 32'(bus.out), 32'h0);
        check("reset_flag", 32'(bus.flag), 32'h0);
        check("reset_step", 32'(bus.step), 32'h0);

        // INVERT
        bus.in   = 11'h005;
        bus.mode = 2'd0;
        bus.en   = 1'b1;
        tick(3);
        check("invert_a", 32'(bus.out), 32'hA);
        bus.in = 11'h00F;
        tick(1);
        check("invert_0", 32'(bus.out), 32'h0);
        check("invert_step", 32'(bus.step), 32'h0);
        bus.en = 1'b0;
        tick(1);
        check("invert_off", 32'(bus.out), 32'h0);

        // WALK, div=2 then div=0 mid-run
        bus.mode = 2'd2;
        bus.div  = 16'd2;
        bus.en   = 1'b1;
        tick(2);
        for (int i = 0; i < 17; i++) begin
            if (i == 13) bus.div = 16'd0;
            tick(1);
            check($sformatf("walk_out[%0d]", i), 32'(bus.out), 32'(walk_out[i]));
            check($sformatf("walk_step[%0d]", i), 32'(bus.step), 32'(walk_stp[i]));
        end

        // WALK -> PASS: one LOAD cycle with out held
        bus.mode = 2'd1;
        bus.in   = 11'h7A3;
        tick(1);
        check("switch_hold0", 32'(bus.out), 32'h1);
        check("switch_step", 32'(bus.step), 32'h0);
        tick(1);
        check("switch_hold1", 32'(bus.out), 32'h1);
        tick(1);
        check("pass_3", 32'(bus.out), 32'h3);
        bus.in = 11'h00C;
        tick(1);
        check("pass_c", 32'(bus.out), 32'hC);
        bus.en = 1'b0;
        tick(1);
        check("pass_off", 32'(bus.out), 32'h0);

        // Flags
        bus.flag_clr = 2'b11;
        tick(3);
        bus.flag_clr = 2'b00;
        tick(1);
        check("flag_cleared", 32'(bus.flag), 32'h0);
        bus.in = 11'h00F;
        tick(1);
        check("flag_lat1", 32'(bus.flag), 32'h0);
        tick(1);
        check("flag_lat2", 32'(bus.flag), 32'h0);
        tick(1);
        check("flag_set", 32'(bus.flag), 32'h3);
        bus.in = 11'h00E;
        tick(3);
        bus.flag_clr = 2'b01;
        bus.in       = 11'h00F;
        tick(1);
        check("flag_clr_now", 32'(bus.flag), 32'h2);
        tick(1);
        check("flag_clr_wait", 32'(bus.flag), 32'h2);
        tick(1);
        check("flag_set_vs_clr", 32'(bus.flag), 32'h3);
        tick(1);
        check("flag_clr_after", 32'(bus.flag), 32'h2);
        bus.flag_clr = 2'b00;
        tick(1);
        check("flag_idle", 32'(bus.flag), 32'h2);

        // LFSR, div=0
        bus.mode = 2'd3;
        bus.div  = 16'd0;
        bus.en   = 1'b1;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check($sformatf("lfsr_out[%0d]", i), 32'(bus.out), 32'(lfsr_out[i]));
            check($sformatf("lfsr_step[%0d]", i), 32'(bus.step), 32'h1);
        end

        // Asynchronous reset mid-run
        wb_rst_n = 1'b0;
        #1;
        check("arst_out", 32'(bus.out), 32'h0);
        check("arst_flag", 32'(bus.flag), 32'h0);
        check("arst_step", 32'(bus.step), 32'h0);
        tick(2);
        wb_rst_n = 1'b1;
        tick(1);
        check("arst_load_out", 32'(bus.out), 32'h0);
        tick(2);
        check("arst_lfsr0", 32'(bus.out), 32'(lfsr_out[0]));
        tick(1);
        check("arst_lfsr1", 32'(bus.out), 32'(lfsr_out[1]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
